// File: rtl/opb_arb_pkg.sv
// opb_arb_pkg: shared FSM state encoding, master index type and round-robin pick for the OPB arbiter
package opb_arb_pkg;
    typedef enum logic [1:0] {IDLE, GRANT, BUSY, TOUT} arb_state_e;
    typedef logic mst_t;
    function automatic mst_t pick(input logic r0, input logic r1, input mst_t last);
        return (r0 && r1) ? ~last : mst_t'(r1);
    endfunction
endpackage

// File: rtl/opb_watchdog.sv
// opb_watchdog: counts select cycles without a slave response and flags expiry on the final counted cycle
module opb_watchdog #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expire
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] MAX = W'(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = clear ? '0 : (en && cnt_q != MAX) ? cnt_q + W'(1) : cnt_q;
        expire = en && !clear && cnt_q == LAST;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
endmodule

// File: rtl/opb_arbiter_2m.sv
// opb_arbiter_2m: two-master round-robin OPB arbiter with bus lock, retry handling and select watchdog
module opb_arbiter_2m #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int RESET_PRIORITY = 0
) (
    input  logic        OPB_Clk,
    input  logic        OPB_Rst_n,
    input  logic        M0_request,
    input  logic        M1_request,
    input  logic        M0_busLock,
    input  logic        M1_busLock,
    input  logic        M0_select,
    input  logic        M1_select,
    input  logic        M0_RNW,
    input  logic        M1_RNW,
    input  logic [0:3]  M0_BE,
    input  logic [0:3]  M1_BE,
    input  logic [0:31] M0_ABus,
    input  logic [0:31] M1_ABus,
    input  logic [0:31] M0_DBus,
    input  logic [0:31] M1_DBus,
    output logic        M0_MGrant,
    output logic        M1_MGrant,
    input  logic        Sl_xferAck,
    input  logic        Sl_errAck,
    input  logic        Sl_retry,
    output logic        OPB_select,
    output logic        OPB_RNW,
    output logic [0:3]  OPB_BE,
    output logic [0:31] OPB_ABus,
    output logic [0:31] OPB_DBus,
    output logic        OPB_xferAck,
    output logic        OPB_errAck,
    output logic        OPB_retry,
    output logic        OPB_timeout
);
    import opb_arb_pkg::*;
    localparam mst_t RST_LAST = (RESET_PRIORITY == 0) ? 1'b1 : 1'b0;
    arb_state_e state_q, state_d;
    mst_t owner_q, owner_d, last_q, last_d;
    logic grant0_q, grant0_d, grant1_q, grant1_d, tout_q, tout_d;
    logic busy, own_sel, own_lock, wd_clear, wd_expire;
    assign busy = state_q == BUSY;
    assign own_sel = owner_q ? M1_select : M0_select;
    assign own_lock = owner_q ? M1_busLock : M0_busLock;
    assign OPB_select = busy && own_sel;
    assign OPB_RNW = busy && (owner_q ? M1_RNW : M0_RNW);
    assign OPB_BE = busy ? (owner_q ? M1_BE : M0_BE) : '0;
    assign OPB_ABus = busy ? (owner_q ? M1_ABus : M0_ABus) : '0;
    assign OPB_DBus = busy ? (owner_q ? M1_DBus : M0_DBus) : '0;
    assign OPB_xferAck = busy && Sl_xferAck;
    assign OPB_errAck = busy && Sl_errAck;
    assign OPB_retry = busy && Sl_retry;
    assign M0_MGrant = grant0_q;
    assign M1_MGrant = grant1_q;
    assign OPB_timeout = tout_q;
    assign wd_clear = (state_q == GRANT && own_sel) || OPB_xferAck || OPB_errAck || OPB_retry;
    opb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
        .clk(OPB_Clk),
        .rst_n(OPB_Rst_n),
        .clear(wd_clear),
        .en(OPB_select),
        .expire(wd_expire)
    );
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d = last_q;
        case (state_q)
            IDLE: if (M0_request || M1_request) begin
                state_d = GRANT;
                owner_d = pick(M0_request, M1_request, last_q);
            end
            GRANT: begin
                state_d = own_sel ? BUSY : IDLE;
                last_d = own_sel ? owner_q : last_q;
            end
            BUSY:
                if (Sl_retry) begin
                    state_d = IDLE;
                    last_d = owner_q;
                end
                else if (wd_expire) state_d = TOUT;
                else if (!own_sel && !own_lock) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        grant0_d = state_d == GRANT && owner_d == 1'b0;
        grant1_d = state_d == GRANT && owner_d == 1'b1;
        tout_d = state_d == TOUT;
    end
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n)
        if (!OPB_Rst_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q <= RST_LAST;
            grant0_q <= 1'b0;
            grant1_q <= 1'b0;
            tout_q <= 1'b0;
        end
        else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q <= last_d;
            grant0_q <= grant0_d;
            grant1_q <= grant1_d;
            tout_q <= tout_d;
        end
endmodule

// File: tb/tb_opb_arbiter_2m.sv
// tb_opb_arbiter_2m: directed scenario tasks with a grant-order scoreboard for opb_arbiter_2m
module tb_opb_arbiter_2m;
    logic OPB_Clk = 1'b0;
    logic OPB_Rst_n = 1'b0;
    logic M0_request, M1_request, M0_busLock, M1_busLock, M0_select, M1_select, M0_RNW, M1_RNW;
    logic [0:3] M0_BE, M1_BE, OPB_BE;
    logic [0:31] M0_ABus, M1_ABus, M0_DBus, M1_DBus, OPB_ABus, OPB_DBus;
    logic M0_MGrant, M1_MGrant, Sl_xferAck, Sl_errAck, Sl_retry;
    logic OPB_select, OPB_RNW, OPB_xferAck, OPB_errAck, OPB_retry, OPB_timeout;
    int total = 0;
    int bad = 0;
    int exp_q[$];

    opb_arbiter_2m #(.TIMEOUT_CYCLES(16), .RESET_PRIORITY(0)) dut (
        .OPB_Clk(OPB_Clk), .OPB_Rst_n(OPB_Rst_n),
        .M0_request(M0_request), .M1_request(M1_request),
        .M0_busLock(M0_busLock), .M1_busLock(M1_busLock),
        .M0_select(M0_select), .M1_select(M1_select),
        .M0_RNW(M0_RNW), .M1_RNW(M1_RNW),
        .M0_BE(M0_BE), .M1_BE(M1_BE),
        .M0_ABus(M0_ABus), .M1_ABus(M1_ABus),
        .M0_DBus(M0_DBus), .M1_DBus(M1_DBus),
        .M0_MGrant(M0_MGrant), .M1_MGrant(M1_MGrant),
        .Sl_xferAck(Sl_xferAck), .Sl_errAck(Sl_errAck), .Sl_retry(Sl_retry),
        .OPB_select(OPB_select), .OPB_RNW(OPB_RNW), .OPB_BE(OPB_BE),
        .OPB_ABus(OPB_ABus), .OPB_DBus(OPB_DBus),
        .OPB_xferAck(OPB_xferAck), .OPB_errAck(OPB_errAck),
        .OPB_retry(OPB_retry), .OPB_timeout(OPB_timeout)
    );

    always #5 OPB_Clk = ~OPB_Clk;

    initial begin
        #200000;
        $display("FAIL global_time_limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge OPB_Clk);
        #2;
    endtask

    task automatic idle_inputs();
        {M0_request, M1_request, M0_busLock, M1_busLock, M0_select, M1_select, M0_RNW, M1_RNW} = '0;
        {M0_BE, M1_BE} = '0;
        M0_ABus = $urandom;
        M1_ABus = $urandom;
        M0_DBus = $urandom;
        M1_DBus = $urandom;
        {Sl_xferAck, Sl_errAck, Sl_retry} = '0;
    endtask

    task automatic do_reset();
        OPB_Rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge OPB_Clk);
        #2 OPB_Rst_n = 1'b1;
    endtask

    task automatic wait_grant(output int who);
        for (int i = 0; i < 8; i++) begin
            if (M0_MGrant || M1_MGrant) break;
            tick();
        end
        who = (M0_MGrant && M1_MGrant) ? 2 : M0_MGrant ? 0 : M1_MGrant ? 1 : -1;
    endtask

    task automatic test_reset();
        OPB_Rst_n = 1'b0;
        idle_inputs();
        M0_request = 1'b1;
        M0_select = 1'b1;
        Sl_xferAck = 1'b1;
        tick();
        total++;
        if ({M0_MGrant, M1_MGrant, OPB_select, OPB_xferAck, OPB_timeout} !== 5'b0 || OPB_ABus !== 32'h0) begin
            bad++;
            $display("FAIL reset_state got=%b abus=%h exp=00000 abus=0", {M0_MGrant, M1_MGrant, OPB_select, OPB_xferAck, OPB_timeout}, OPB_ABus);
        end
        M0_select = 1'b0;
        Sl_xferAck = 1'b0;
        OPB_Rst_n = 1'b1;
        tick();
        total++;
        if ({M0_MGrant, M1_MGrant} !== 2'b10) begin
            bad++;
            $display("FAIL first_arb_after_reset got=%b exp=10", {M0_MGrant, M1_MGrant});
        end
    endtask

    task automatic test_basic();
        logic [0:31] a;
        do_reset();
        a = 32'hA0A0_0004;
        M0_ABus = a;
        M0_DBus = 32'h5566_7788;
        M0_request = 1'b1;
        tick();
        total++;
        if ({M0_MGrant, M1_MGrant, OPB_select} !== 3'b100) begin
            bad++;
            $display("FAIL basic_grant got=%b exp=100", {M0_MGrant, M1_MGrant, OPB_select});
        end
        M0_request = 1'b0;
        M0_select = 1'b1;
        M0_RNW = 1'b1;
        M0_BE = 4'hC;
        tick();
        total++;
        if ({M0_MGrant, OPB_select, OPB_RNW, OPB_BE} !== 7'b0111100 || OPB_ABus !== a || OPB_DBus !== 32'h5566_7788) begin
            bad++;
            $display("FAIL basic_busy_mux got=%b abus=%h dbus=%h exp=0111100 abus=%h dbus=55667788", {M0_MGrant, OPB_select, OPB_RNW, OPB_BE}, OPB_ABus, OPB_DBus, a);
        end
        M0_ABus = 32'h0000_1234;
        M1_select = 1'b1;
        M1_ABus = 32'hFFFF_0000;
        #1;
        total++;
        if (OPB_ABus !== 32'h0000_1234) begin
            bad++;
            $display("FAIL basic_follow_owner got=%h exp=00001234", OPB_ABus);
        end
        Sl_xferAck = 1'b1;
        #1;
        total++;
        if (OPB_xferAck !== 1'b1) begin
            bad++;
            $display("FAIL basic_ack_pass got=%b exp=1", OPB_xferAck);
        end
        tick();
        Sl_xferAck = 1'b0;
        M0_select = 1'b0;
        M1_select = 1'b0;
        tick();
        Sl_xferAck = 1'b1;
        #1;
        total++;
        if ({M0_MGrant, M1_MGrant, OPB_select, OPB_xferAck} !== 4'b0 || OPB_ABus !== 32'h0) begin
            bad++;
            $display("FAIL basic_idle got=%b abus=%h exp=0000 abus=0", {M0_MGrant, M1_MGrant, OPB_select, OPB_xferAck}, OPB_ABus);
        end
        Sl_xferAck = 1'b0;
    endtask

    task automatic test_withdraw();
        int who, e;
        do_reset();
        M0_request = 1'b1;
        tick();
        M0_request = 1'b0;
        M0_select = 1'b1;
        tick();
        M0_select = 1'b0;
        tick();
        M1_request = 1'b1;
        tick();
        M1_request = 1'b0;
        total++;
        if ({M0_MGrant, M1_MGrant} !== 2'b01) begin
            bad++;
            $display("FAIL withdraw_grant got=%b exp=01", {M0_MGrant, M1_MGrant});
        end
        tick();
        total++;
        if ({M0_MGrant, M1_MGrant, OPB_select} !== 3'b000) begin
            bad++;
            $display("FAIL withdraw_drop got=%b exp=000", {M0_MGrant, M1_MGrant, OPB_select});
        end
        exp_q.push_back(1);
        M0_request = 1'b1;
        M1_request = 1'b1;
        tick();
        wait_grant(who);
        e = exp_q.pop_front();
        total++;
        if (who !== e) begin
            bad++;
            $display("FAIL withdraw_no_last_update got=%0d exp=%0d", who, e);
        end
    endtask

    task automatic test_alternate();
        int who, e;
        do_reset();
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(0);
        exp_q.push_back(1);
        M0_request = 1'b1;
        M1_request = 1'b1;
        tick();
        for (int n = 0; n < 4; n++) begin
            wait_grant(who);
            e = exp_q.pop_front();
            total++;
            if (who !== e) begin
                bad++;
                $display("FAIL alternate_%0d got=%0d exp=%0d", n, who, e);
            end
            M0_select = who == 0;
            M1_select = who == 1;
            tick();
            total++;
            if (OPB_select !== 1'b1) begin
                bad++;
                $display("FAIL alternate_busy_%0d got=%b exp=1", n, OPB_select);
            end
            M0_select = 1'b0;
            M1_select = 1'b0;
            Sl_xferAck = 1'b1;
            tick();
            Sl_xferAck = 1'b0;
            tick();
        end
    endtask

    task automatic test_lock();
        int m0_grants;
        do_reset();
        M1_ABus = 32'h1111_0000;
        M1_request = 1'b1;
        tick();
        total++;
        if ({M0_MGrant, M1_MGrant} !== 2'b01) begin
            bad++;
            $display("FAIL lock_first_grant got=%b exp=01", {M0_MGrant, M1_MGrant});
        end
        M1_request = 1'b0;
        M1_select = 1'b1;
        M1_busLock = 1'b1;
        M0_request = 1'b1;
        tick();
        m0_grants = 0;
        for (int n = 0; n < 3; n++) begin
            if (n > 0) begin
                M1_select = 1'b1;
                tick();
                m0_grants += int'(M0_MGrant);
            end
            total++;
            if (OPB_select !== 1'b1 || OPB_ABus !== 32'h1111_0000) begin
                bad++;
                $display("FAIL lock_xfer_%0d sel=%b abus=%h exp sel=1 abus=11110000", n, OPB_select, OPB_ABus);
            end
            M1_select = 1'b0;
            Sl_xferAck = 1'b1;
            tick();
            Sl_xferAck = 1'b0;
            m0_grants += int'(M0_MGrant);
        end
        M1_busLock = 1'b0;
        tick();
        m0_grants += int'(M0_MGrant);
        total++;
        if (m0_grants !== 0) begin
            bad++;
            $display("FAIL lock_m0_waits got=%0d grants exp=0", m0_grants);
        end
        tick();
        total++;
        if ({M0_MGrant, M1_MGrant} !== 2'b10) begin
            bad++;
            $display("FAIL lock_release_grant got=%b exp=10", {M0_MGrant, M1_MGrant});
        end
    endtask

    task automatic test_timeout();
        do_reset();
        M0_request = 1'b1;
        tick();
        M0_request = 1'b0;
        M0_select = 1'b1;
        tick();
        for (int k = 1; k <= 16; k++) begin
            total++;
            if ({OPB_timeout, OPB_select} !== 2'b01) begin
                bad++;
                $display("FAIL timeout_count_%0d got=%b exp=01", k, {OPB_timeout, OPB_select});
            end
            tick();
        end
        total++;
        if ({OPB_timeout, OPB_select} !== 2'b10 || OPB_ABus !== 32'h0) begin
            bad++;
            $display("FAIL timeout_pulse got=%b abus=%h exp=10 abus=0", {OPB_timeout, OPB_select}, OPB_ABus);
        end
        tick();
        total++;
        if ({OPB_timeout, OPB_select, M0_MGrant, M1_MGrant} !== 4'b0) begin
            bad++;
            $display("FAIL timeout_after got=%b exp=0000", {OPB_timeout, OPB_select, M0_MGrant, M1_MGrant});
        end
        M0_select = 1'b0;
        tick();
        M0_request = 1'b1;
        tick();
        M0_request = 1'b0;
        M0_select = 1'b1;
        tick();
        repeat (15) tick();
        Sl_xferAck = 1'b1;
        tick();
        Sl_xferAck = 1'b0;
        total++;
        if ({OPB_timeout, OPB_select} !== 2'b01) begin
            bad++;
            $display("FAIL timeout_ack_wins got=%b exp=01", {OPB_timeout, OPB_select});
        end
        M0_select = 1'b0;
        tick();
        total++;
        if ({OPB_timeout, OPB_select} !== 2'b00) begin
            bad++;
            $display("FAIL timeout_ack_end got=%b exp=00", {OPB_timeout, OPB_select});
        end
    endtask

    task automatic test_retry();
        int who, e;
        do_reset();
        M0_busLock = 1'b1;
        M0_request = 1'b1;
        M1_request = 1'b1;
        exp_q.push_back(0);
        tick();
        wait_grant(who);
        e = exp_q.pop_front();
        total++;
        if (who !== e) begin
            bad++;
            $display("FAIL retry_first got=%0d exp=%0d", who, e);
        end
        M0_select = 1'b1;
        tick();
        Sl_retry = 1'b1;
        #1;
        total++;
        if ({OPB_select, OPB_retry} !== 2'b11) begin
            bad++;
            $display("FAIL retry_pass got=%b exp=11", {OPB_select, OPB_retry});
        end
        tick();
        total++;
        if ({OPB_select, OPB_retry} !== 2'b00) begin
            bad++;
            $display("FAIL retry_exit got=%b exp=00", {OPB_select, OPB_retry});
        end
        Sl_retry = 1'b0;
        M0_select = 1'b0;
        exp_q.push_back(1);
        tick();
        wait_grant(who);
        e = exp_q.pop_front();
        total++;
        if (who !== e) begin
            bad++;
            $display("FAIL retry_next_owner got=%0d exp=%0d", who, e);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        do_reset();
        M0_request = 1'b1;
        tick();
        M0_request = 1'b0;
        M0_select = 1'b1;
        M0_ABus = 32'hDEAD_BEEF;
        tick();
        repeat (3) tick();
        total++;
        if (OPB_select !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_busy got=%b exp=1", OPB_select);
        end
        OPB_Rst_n = 1'b0;
        #1;
        total++;
        if ({OPB_select, OPB_RNW, M0_MGrant, M1_MGrant, OPB_timeout} !== 5'b0 || OPB_ABus !== 32'h0 || OPB_DBus !== 32'h0) begin
            bad++;
            $display("FAIL rstmid_async got=%b abus=%h dbus=%h exp=00000 abus=0 dbus=0", {OPB_select, OPB_RNW, M0_MGrant, M1_MGrant, OPB_timeout}, OPB_ABus, OPB_DBus);
        end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen |= OPB_timeout;
        end
        OPB_Rst_n = 1'b1;
        M0_select = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen |= OPB_timeout;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_no_timeout got=%b exp=0", seen);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_basic();
        test_withdraw();
        test_alternate();
        test_lock();
        test_timeout();
        test_retry();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
